// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 set-2 keyboard decoder.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_BRK   = 8'hF0;
   localparam logic [7:0] PS2_PAUSE = 8'hE1;

   localparam int unsigned FRAME_BITS = 11;
   localparam logic [2:0]  PAUSE_SKIP = 3'd7;

   // Keyboard status/ack codes that never map to a key event
   localparam int unsigned N_IGNORED = 6;
   localparam logic [7:0] IGNORED_CODES [N_IGNORED] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK,
      ST_PAUSE
   } prefix_state_t;

   function automatic logic is_ignored(input logic [7:0] code);
      logic hit;
      hit = 1'b0;
      for (int unsigned i = 0; i < N_IGNORED; i++)
         if (code == IGNORED_CODES[i]) hit = 1'b1;
      return hit;
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input sync, clock glitch filter, 11-bit frame capture,
// start/parity/stop checks and intra-frame timeout.
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int unsigned FILT_LEN    = 8,
   parameter int unsigned TIMEOUT     = 24000,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       byte_valid,
   output logic [7:0] rx_byte,
   output logic       frame_err
);

   localparam int unsigned FILT_W = $clog2(FILT_LEN + 1);
   localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] dat_sync;
   logic                   clk_s;
   logic                   dat_s;
   logic                   clk_filt;
   logic [FILT_W-1:0]      filt_cnt;
   logic                   fall;
   logic [9:0]             shreg;
   logic [3:0]             bit_idx;
   logic [TO_W-1:0]        to_cnt;
   logic [10:0]            frame;
   logic                   frame_ok;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         clk_sync <= '1;
         dat_sync <= '1;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
         dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat_in};
      end
   end

   always_comb begin
      clk_s    = clk_sync[SYNC_STAGES-1];
      dat_s    = dat_sync[SYNC_STAGES-1];
      // The FILT_LEN-th consecutive differing sample is the one that flips clk_filt
      fall     = clk_filt && !clk_s && (filt_cnt == FILT_W'(FILT_LEN - 1));
      frame    = {dat_s, shreg};
      frame_ok = !frame[0] && (^frame[9:1]) && frame[10];
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         clk_filt <= 1'b1;
         filt_cnt <= '0;
      end else if (clk_s == clk_filt) begin
         filt_cnt <= '0;
      end else if (filt_cnt == FILT_W'(FILT_LEN - 1)) begin
         clk_filt <= clk_s;
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         shreg      <= '0;
         bit_idx    <= '0;
         to_cnt     <= '0;
         byte_valid <= 1'b0;
         rx_byte    <= '0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         // A falling edge takes priority over an expiring timeout
         if (fall) begin
            to_cnt <= '0;
            shreg  <= {dat_s, shreg[9:1]};
            if (bit_idx == 4'(FRAME_BITS - 1)) begin
               bit_idx    <= '0;
               byte_valid <= frame_ok;
               frame_err  <= !frame_ok;
               rx_byte    <= frame[8:1];
            end else begin
               bit_idx <= bit_idx + 1'b1;
            end
         end else if (bit_idx != '0) begin
            if (to_cnt == TO_W'(TIMEOUT - 1)) begin
               to_cnt    <= '0;
               bit_idx   <= '0;
               frame_err <= 1'b1;
            end else begin
               to_cnt <= to_cnt + 1'b1;
            end
         end else begin
            to_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end producing the 11-bit toggle-style ps2_key event word
// from raw PS/2 pins, handling E0/F0/E1 scan-code set 2 prefixes.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int unsigned FILT_LEN    = 8,
   parameter int unsigned TIMEOUT     = 24000,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ps2_clk_in,
   input  logic        ps2_dat_in,
   output logic [10:0] ps2_key,
   output logic        frame_err
);

   logic          byte_valid;
   logic [7:0]    rx_byte;
   logic          rx_err;
   prefix_state_t state;
   logic [2:0]    skip;
   logic          is_ext;
   logic          is_brk;

   ps2_frame_rx #(
      .FILT_LEN    (FILT_LEN),
      .TIMEOUT     (TIMEOUT),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_rx (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .ps2_clk_in (ps2_clk_in),
      .ps2_dat_in (ps2_dat_in),
      .byte_valid (byte_valid),
      .rx_byte    (rx_byte),
      .frame_err  (rx_err)
   );

   assign frame_err = rx_err;

   always_comb begin
      is_ext = (state == ST_EXT) || (state == ST_EXT_BRK);
      is_brk = (state == ST_BRK) || (state == ST_EXT_BRK);
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         skip    <= '0;
         ps2_key <= '0;
      end else if (rx_err) begin
         state <= ST_IDLE;
         skip  <= '0;
      end else if (byte_valid) begin
         if (state == ST_PAUSE) begin
            skip <= skip - 3'd1;
            if (skip <= 3'd1) state <= ST_IDLE;
         end else if (rx_byte == PS2_EXT) begin
            state <= is_brk ? ST_EXT_BRK : ST_EXT;
         end else if (rx_byte == PS2_BRK) begin
            state <= is_ext ? ST_EXT_BRK : ST_BRK;
         end else if (rx_byte == PS2_PAUSE) begin
            state <= ST_PAUSE;
            skip  <= PAUSE_SKIP;
         end else if (is_ignored(rx_byte)) begin
            state <= ST_IDLE;
         end else begin
            ps2_key <= {~ps2_key[10], ~is_brk, is_ext, rx_byte};
            state   <= ST_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives PS/2 frames bit by bit and checks
// the published event word, toggle count and frame_err pulses.
module tb_ps2_key_decoder;

   localparam int unsigned TB_TIMEOUT = 1000;
   localparam int          HALF       = 20;
   localparam int          GAP        = 40;

   logic        clk;
   logic        reset;
   logic        ps2c;
   logic        ps2d;
   logic [10:0] ps2_key;
   logic        frame_err;

   int vectors     = 0;
   int miscompares = 0;
   int toggles     = 0;
   int err_pulses  = 0;
   int err_cyc     = 0;
   logic prev10    = 1'b0;
   logic prev_err  = 1'b0;

   ps2_key_decoder #(
      .FILT_LEN    (8),
      .TIMEOUT     (TB_TIMEOUT),
      .SYNC_STAGES (2)
   ) dut (
      .clk_sys    (clk),
      .reset      (reset),
      .ps2_clk_in (ps2c),
      .ps2_dat_in (ps2d),
      .ps2_key    (ps2_key),
      .frame_err  (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ps2_key[10] !== prev10) toggles++;
      prev10 = ps2_key[10];
      if (frame_err === 1'b1) err_cyc++;
      if (frame_err === 1'b1 && prev_err !== 1'b1) err_pulses++;
      prev_err = frame_err;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic ps2_bit(input logic b);
      ps2d = b;
      tick(HALF);
      ps2c = 1'b0;
      tick(HALF);
      ps2c = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic bad_par);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit((~^b) ^ bad_par);
      ps2_bit(1'b1);
      ps2d = 1'b1;
      tick(GAP);
      settle();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ps2c  = 1'b1;
      ps2d  = 1'b1;
      tick(5);
      settle();
      vectors++;
      if (ps2_key !== 11'h000) begin
         miscompares++;
         $display("FAIL reset_key: got %h want %h", ps2_key, 11'h000);
      end
      vectors++;
      if (frame_err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_err: got %b want 0", frame_err);
      end
      reset = 1'b0;
      tick(5);
      settle();
   endtask

   task automatic test_make();
      int t0, e0;
      t0 = toggles; e0 = err_pulses;
      send_byte(8'h1C, 1'b0);
      vectors++;
      if (ps2_key[9:0] !== 10'h21C) begin
         miscompares++;
         $display("FAIL make_key: got %h want %h", ps2_key[9:0], 10'h21C);
      end
      vectors++;
      if (toggles - t0 !== 1) begin
         miscompares++;
         $display("FAIL make_toggles: got %0d want 1", toggles - t0);
      end
      vectors++;
      if (err_pulses - e0 !== 0) begin
         miscompares++;
         $display("FAIL make_err: got %0d want 0", err_pulses - e0);
      end
   endtask

   task automatic test_back_to_back();
      int t0;
      t0 = toggles;
      send_byte(8'h1C, 1'b0);
      send_byte(8'h1C, 1'b0);
      vectors++;
      if (toggles - t0 !== 2) begin
         miscompares++;
         $display("FAIL repeat_toggles: got %0d want 2", toggles - t0);
      end
      vectors++;
      if (ps2_key[9:0] !== 10'h21C) begin
         miscompares++;
         $display("FAIL repeat_key: got %h want %h", ps2_key[9:0], 10'h21C);
      end
   endtask

   task automatic test_break();
      int t0;
      t0 = toggles;
      send_byte(8'hF0, 1'b0);
      send_byte(8'h1C, 1'b0);
      vectors++;
      if (ps2_key[9:0] !== 10'h01C) begin
         miscompares++;
         $display("FAIL break_key: got %h want %h", ps2_key[9:0], 10'h01C);
      end
      vectors++;
      if (toggles - t0 !== 1) begin
         miscompares++;
         $display("FAIL break_toggles: got %0d want 1", toggles - t0);
      end
   endtask

   task automatic test_extended();
      int t0;
      t0 = toggles;
      send_byte(8'hE0, 1'b0);
      send_byte(8'h75, 1'b0);
      vectors++;
      if (ps2_key[9:0] !== 10'h375) begin
         miscompares++;
         $display("FAIL ext_make_key: got %h want %h", ps2_key[9:0], 10'h375);
      end
      vectors++;
      if (toggles - t0 !== 1) begin
         miscompares++;
         $display("FAIL ext_make_toggles: got %0d want 1", toggles - t0);
      end
      send_byte(8'hE0, 1'b0);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h75, 1'b0);
      vectors++;
      if (ps2_key[9:0] !== 10'h175) begin
         miscompares++;
         $display("FAIL ext_break_key: got %h want %h", ps2_key[9:0], 10'h175);
      end
      vectors++;
      if (toggles - t0 !== 2) begin
         miscompares++;
         $display("FAIL ext_total_toggles: got %0d want 2", toggles - t0);
      end
   endtask

   task automatic test_parity_error();
      int t0, e0, c0;
      t0 = toggles; e0 = err_pulses; c0 = err_cyc;
      send_byte(8'h29, 1'b1);
      vectors++;
      if (err_pulses - e0 !== 1) begin
         miscompares++;
         $display("FAIL parity_err_pulses: got %0d want 1", err_pulses - e0);
      end
      vectors++;
      if (err_cyc - c0 !== 1) begin
         miscompares++;
         $display("FAIL parity_err_width: got %0d want 1", err_cyc - c0);
      end
      vectors++;
      if (toggles - t0 !== 0) begin
         miscompares++;
         $display("FAIL parity_toggles: got %0d want 0", toggles - t0);
      end
      vectors++;
      if (ps2_key[9:0] !== 10'h175) begin
         miscompares++;
         $display("FAIL parity_key_held: got %h want %h", ps2_key[9:0], 10'h175);
      end
      send_byte(8'h29, 1'b0);
      vectors++;
      if (ps2_key[9:0] !== 10'h229) begin
         miscompares++;
         $display("FAIL parity_recover_key: got %h want %h", ps2_key[9:0], 10'h229);
      end
   endtask

   task automatic test_timeout();
      int t0, e0, c0;
      t0 = toggles; e0 = err_pulses; c0 = err_cyc;
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      ps2d = 1'b1;
      tick(TB_TIMEOUT + 10);
      settle();
      vectors++;
      if (err_pulses - e0 !== 1) begin
         miscompares++;
         $display("FAIL timeout_err_pulses: got %0d want 1", err_pulses - e0);
      end
      vectors++;
      if (err_cyc - c0 !== 1) begin
         miscompares++;
         $display("FAIL timeout_err_width: got %0d want 1", err_cyc - c0);
      end
      vectors++;
      if (toggles - t0 !== 0) begin
         miscompares++;
         $display("FAIL timeout_toggles: got %0d want 0", toggles - t0);
      end
      send_byte(8'h05, 1'b0);
      vectors++;
      if (ps2_key[9:0] !== 10'h205) begin
         miscompares++;
         $display("FAIL timeout_recover_key: got %h want %h", ps2_key[9:0], 10'h205);
      end
   endtask

   task automatic test_pause();
      int t0;
      logic [7:0] seq [8];
      seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      t0 = toggles;
      for (int i = 0; i < 8; i++) send_byte(seq[i], 1'b0);
      vectors++;
      if (toggles - t0 !== 0) begin
         miscompares++;
         $display("FAIL pause_toggles: got %0d want 0", toggles - t0);
      end
      vectors++;
      if (ps2_key[9:0] !== 10'h205) begin
         miscompares++;
         $display("FAIL pause_key_held: got %h want %h", ps2_key[9:0], 10'h205);
      end
      send_byte(8'h1C, 1'b0);
      vectors++;
      if (ps2_key[9:0] !== 10'h21C) begin
         miscompares++;
         $display("FAIL pause_after_key: got %h want %h", ps2_key[9:0], 10'h21C);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] b;
      b = 8'h3A;
      ps2_bit(1'b0);
      ps2_bit(b[0]);
      ps2_bit(b[1]);
      ps2_bit(b[2]);
      ps2d = b[3];
      tick(HALF);
      ps2c = 1'b0;
      tick(5);
      reset = 1'b1;
      tick(2);
      settle();
      vectors++;
      if (ps2_key !== 11'h000) begin
         miscompares++;
         $display("FAIL midreset_key: got %h want %h", ps2_key, 11'h000);
      end
      ps2c = 1'b1;
      ps2d = 1'b1;
      tick(30);
      reset = 1'b0;
      tick(5);
      settle();
      vectors++;
      if (ps2_key !== 11'h000) begin
         miscompares++;
         $display("FAIL midreset_no_event: got %h want %h", ps2_key, 11'h000);
      end
      send_byte(8'h1C, 1'b0);
      vectors++;
      if (ps2_key !== 11'h61C) begin
         miscompares++;
         $display("FAIL midreset_next_key: got %h want %h", ps2_key, 11'h61C);
      end
   endtask

   initial begin
      test_reset();
      test_make();
      test_back_to_back();
      test_break();
      test_extended();
      test_parity_error();
      test_timeout();
      test_pause();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
